// File: rtl/nanci_pkg.sv
// Shared types and PE word field helpers for the Nanci result collector.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package nanci_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        CAPTURE = 2'd2,
        DRAIN   = 2'd3
    } collect_state_t;

    // Field positions for the default 3+3 bit PE word; the functions below
    // give the same positions for any width pair.
    localparam int PE_ADDR_WIDTH = 3;
    localparam int PE_DATA_WIDTH = 3;
    localparam int PE_DATA_LSB   = 0;
    localparam int PE_DATA_MSB   = PE_DATA_WIDTH - 1;
    localparam int PE_ADDR_LSB   = PE_DATA_WIDTH;
    localparam int PE_ADDR_MSB   = PE_ADDR_WIDTH + PE_DATA_WIDTH - 1;

    function automatic int pe_data_msb(input int dw);
        return dw - 1;
    endfunction

    function automatic int pe_addr_lsb(input int dw);
        return dw;
    endfunction

    function automatic int pe_addr_msb(input int aw, input int dw);
        return aw + dw - 1;
    endfunction

endpackage

// File: rtl/nanci_result_mem.sv
// Result buffer: N x DATA_WIDTH register array, one write port, one async read port.
// Latency: write visible on the read port the cycle after the write edge.
// Backpressure: none; writes are accepted every cycle wr_en is high.
module nanci_result_mem #(
    parameter int N          = 8,
    parameter int DATA_WIDTH = 3,
    parameter int IDX_W      = 3
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [IDX_W-1:0]      wr_idx,
    input  logic [DATA_WIDTH-1:0] wr_dat,
    input  logic [IDX_W-1:0]      rd_idx,
    output logic [DATA_WIDTH-1:0] rd_dat
);

    logic [DATA_WIDTH-1:0] mem [N];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_dat;
        end
    end

    assign rd_dat = mem[rd_idx];

endmodule

// File: rtl/nanci_result_collector.sv
// Captures {addr,data} PE words into a buffer, then drains it in address order.
// Latency: drain entry 0 valid the cycle after the N-th capture; 1 word/cycle drain.
// Backpressure: none on capture; drain holds o_valid/o_addr/o_data until i_ready. Checks: NANCI_COLLECT_CHECK_EN.
module nanci_result_collector
    import nanci_pkg::*;
#(
    parameter int N           = 8,
    parameter int ADDR_WIDTH  = 3,
    parameter int DATA_WIDTH  = 3,
    parameter int SORT_CYCLES = 1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             i_start,
    input  logic                             i_valid,
    input  logic [ADDR_WIDTH+DATA_WIDTH-1:0] i_PE,
    output logic [ADDR_WIDTH-1:0]            o_addr,
    output logic [DATA_WIDTH-1:0]            o_data,
    output logic                             o_valid,
    input  logic                             i_ready,
    output logic                             o_busy,
    output logic                             o_done,
    output logic                             o_err
);

    localparam int CNT_W    = $clog2(N + 1);
    localparam int WAIT_W   = (SORT_CYCLES > 0) ? $clog2(SORT_CYCLES + 1) : 1;
    localparam int IDX_W    = (N > 1) ? $clog2(N) : 1;
    localparam int ADDR_MSB = pe_addr_msb(ADDR_WIDTH, DATA_WIDTH);
    localparam int ADDR_LSB = pe_addr_lsb(DATA_WIDTH);
    localparam int DATA_MSB = pe_data_msb(DATA_WIDTH);

    localparam logic [CNT_W-1:0]      LAST      = CNT_W'(N - 1);
    localparam logic [WAIT_W-1:0]     WAIT_LOAD = WAIT_W'(SORT_CYCLES);
    localparam logic [ADDR_WIDTH:0]   N_LIM     = (ADDR_WIDTH + 1)'(N);

    collect_state_t state, state_nxt;

    logic [WAIT_W-1:0]     wait_cnt;
    logic [CNT_W-1:0]      cnt;
    logic [CNT_W-1:0]      idx;
    logic [CNT_W-1:0]      idx_nxt;
    logic [ADDR_WIDTH-1:0] pe_addr;
    logic [DATA_WIDTH-1:0] pe_data;
    logic [IDX_W-1:0]      wr_idx;
    logic [IDX_W-1:0]      rd_idx;
    logic [DATA_WIDTH-1:0] rd_dat;
    logic [DATA_WIDTH-1:0] first_dat;
    logic                  addr_ok;
    logic                  cap_vld;
    logic                  wr_en;
    logic                  cap_last;
    logic                  drain_hs;
    logic                  drain_last;

    assign pe_addr    = i_PE[ADDR_MSB:ADDR_LSB];
    assign pe_data    = i_PE[DATA_MSB:0];
    assign wr_idx     = pe_addr[IDX_W-1:0];
    assign addr_ok    = {1'b0, pe_addr} < N_LIM;
    assign cap_vld    = (state == CAPTURE) && i_valid;
    assign wr_en      = cap_vld && addr_ok;
    assign cap_last   = wr_en && (cnt == LAST);
    assign drain_hs   = (state == DRAIN) && o_valid && i_ready;
    assign drain_last = drain_hs && (idx == LAST);
    assign idx_nxt    = idx + 1'b1;
    assign o_busy     = (state != IDLE);

    // During capture the read port looks at entry 0 so the first drain word
    // can be loaded on the transition edge; the bypass covers a final write to 0.
    assign rd_idx    = (state == CAPTURE) ? '0 : IDX_W'(idx_nxt);
    assign first_dat = (pe_addr == '0) ? pe_data : rd_dat;

    nanci_result_mem #(
        .N          (N),
        .DATA_WIDTH (DATA_WIDTH),
        .IDX_W      (IDX_W)
    ) u_mem (
        .clk    (clk),
        .wr_en  (wr_en),
        .wr_idx (wr_idx),
        .wr_dat (pe_data),
        .rd_idx (rd_idx),
        .rd_dat (rd_dat)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // WAIT lasts SORT_CYCLES cycles; with no sort delay capture opens straight after start.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (i_start) state_nxt = (SORT_CYCLES == 0) ? CAPTURE : WAIT;
            WAIT:    if (wait_cnt <= WAIT_W'(1)) state_nxt = CAPTURE;
            CAPTURE: if (cap_last) state_nxt = DRAIN;
            DRAIN:   if (drain_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wait_cnt <= '0;
            cnt      <= '0;
            idx      <= '0;
            o_addr   <= '0;
            o_data   <= '0;
            o_valid  <= 1'b0;
            o_done   <= 1'b0;
        end else begin
            o_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_start) begin
                        wait_cnt <= WAIT_LOAD;
                        cnt      <= '0;
                    end
                end
                WAIT: wait_cnt <= wait_cnt - 1'b1;
                CAPTURE: begin
                    if (wr_en) begin
                        cnt <= cnt + 1'b1;
                    end
                    if (cap_last) begin
                        idx     <= '0;
                        o_addr  <= '0;
                        o_data  <= first_dat;
                        o_valid <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (drain_last) begin
                        o_valid <= 1'b0;
                        o_done  <= 1'b1;
                    end else if (drain_hs) begin
                        idx    <= idx_nxt;
                        o_addr <= ADDR_WIDTH'(idx_nxt);
                        o_data <= rd_dat;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef NANCI_COLLECT_CHECK_EN
    logic [N-1:0] seen;
    logic         err_q;
    logic         err_set;

    assign err_set = (cap_vld && !addr_ok)
                   || (wr_en && seen[wr_idx])
                   || ((state == WAIT) && i_valid);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seen  <= '0;
            err_q <= 1'b0;
        end else if ((state == IDLE) && i_start) begin
            seen  <= '0;
            err_q <= 1'b0;
        end else begin
            if (wr_en) begin
                seen[wr_idx] <= 1'b1;
            end
            if (err_set) begin
                err_q <= 1'b1;
            end
        end
    end

    assign o_err = err_q;
`else
    assign o_err = 1'b0;
`endif

endmodule

// File: tb/tb_nanci_result_collector.sv
// Directed bench: N=4 collector with SORT_CYCLES=1 (main) and SORT_CYCLES=0 (second instance).
module tb_nanci_result_collector;

    localparam int N  = 4;
    localparam int AW = 3;
    localparam int DW = 3;
`ifdef NANCI_COLLECT_CHECK_EN
    localparam logic CHK = 1'b1;
`else
    localparam logic CHK = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          start, vld, rdy;
    logic [5:0]    pe;
    logic [AW-1:0] oaddr;
    logic [DW-1:0] odata;
    logic          ovld, busy, done, err;

    logic          start_z, vld_z, rdy_z;
    logic [5:0]    pe_z;
    logic [AW-1:0] oaddr_z;
    logic [DW-1:0] odata_z;
    logic          ovld_z, busy_z, done_z, err_z;

    int total = 0;
    int bad   = 0;
    int done_cnt = 0;
    int done_cnt_z = 0;
    int d0;
    logic [2:0] ez [4];

    nanci_result_collector #(.N(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SORT_CYCLES(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .i_start(start), .i_valid(vld), .i_PE(pe),
        .o_addr(oaddr), .o_data(odata), .o_valid(ovld), .i_ready(rdy),
        .o_busy(busy), .o_done(done), .o_err(err)
    );

    nanci_result_collector #(.N(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SORT_CYCLES(0)) u_dut_z (
        .clk(clk), .rst_n(rst_n), .i_start(start_z), .i_valid(vld_z), .i_PE(pe_z),
        .o_addr(oaddr_z), .o_data(odata_z), .o_valid(ovld_z), .i_ready(rdy_z),
        .o_busy(busy_z), .o_done(done_z), .o_err(err_z)
    );

    always @(posedge clk) begin
        #1;
        if (done)   done_cnt++;
        if (done_z) done_cnt_z++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic cap(input logic [5:0] w);
        vld = 1'b1;
        pe  = w;
        tick();
        vld = 1'b0;
        pe  = '0;
    endtask

    task automatic begin_run();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_after_start", busy, 1);
    endtask

    task automatic drain(input string tag, input logic [2:0] e0, input logic [2:0] e1,
                         input logic [2:0] e2, input logic [2:0] e3,
                         input int stall_at, input int stall_n);
        logic [2:0] e [4];
        int dc;
        e  = '{e0, e1, e2, e3};
        dc = done_cnt;
        rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i == stall_at) begin
                rdy = 1'b0;
                for (int k = 0; k < stall_n; k++) begin
                    tick();
                    chk({tag, "_stall_vld"},  ovld,  1);
                    chk({tag, "_stall_addr"}, oaddr, i);
                    chk({tag, "_stall_data"}, odata, e[i]);
                end
                rdy = 1'b1;
            end
            chk({tag, "_vld"},  ovld,  1);
            chk({tag, "_addr"}, oaddr, i);
            chk({tag, "_data"}, odata, e[i]);
            tick();
        end
        chk({tag, "_done"},      done, 1);
        chk({tag, "_idle"},      busy, 0);
        chk({tag, "_vld_low"},   ovld, 0);
        tick();
        chk({tag, "_done_pulse"}, done, 0);
        chk({tag, "_done_once"},  done_cnt, dc + 1);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0; vld = 1'b0; pe = '0; rdy = 1'b1;
        start_z = 1'b0; vld_z = 1'b0; pe_z = '0; rdy_z = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;

        chk("rst_valid", ovld, 0);
        chk("rst_busy",  busy, 0);
        chk("rst_done",  done, 0);
        chk("rst_err",   err,  0);
        chk("rst_addr",  oaddr, 0);
        chk("rst_data",  odata, 0);
        chk("rst_busy_z", busy_z, 0);

        // Basic run
        begin_run();
        tick();
        chk("r1_no_vld_yet", ovld, 0);
        cap(6'b011101);
        cap(6'b000010);
        cap(6'b010111);
        cap(6'b001000);
        drain("r1", 3'd2, 3'd0, 3'd7, 3'd5, -1, 0);
        chk("r1_err", err, 0);

        // Valid during WAIT is ignored; backpressure on entry 1
        begin_run();
        vld = 1'b1;
        pe  = 6'b000111;
        tick();
        vld = 1'b0;
        pe  = '0;
        chk("r2_err_wait_valid", err, CHK);
        chk("r2_no_vld", ovld, 0);
        cap(6'b000001);
        cap(6'b001011);
        cap(6'b010100);
        cap(6'b011110);
        drain("r2", 3'd1, 3'd3, 3'd4, 3'd6, 1, 3);

        // Out-of-range address
        begin_run();
        chk("r3_err_cleared", err, 0);
        tick();
        cap(6'b111011);
        chk("r3_err_oob", err, CHK);
        cap(6'b000100);
        cap(6'b001101);
        cap(6'b010110);
        chk("r3_oob_not_counted", ovld, 0);
        chk("r3_still_busy", busy, 1);
        cap(6'b011001);
        drain("r3", 3'd4, 3'd5, 3'd6, 3'd1, -1, 0);

        // Duplicate address; entry 3 keeps its stale value from r3
        begin_run();
        tick();
        cap(6'b010001);
        chk("r4_err_first", err, 0);
        cap(6'b010110);
        chk("r4_err_dup", err, CHK);
        cap(6'b000011);
        cap(6'b001100);
        drain("r4", 3'd3, 3'd4, 3'd6, 3'd1, -1, 0);

        // Reset during drain at index 2
        begin_run();
        tick();
        cap(6'b011101);
        cap(6'b000010);
        cap(6'b010111);
        cap(6'b001000);
        d0  = done_cnt;
        rdy = 1'b1;
        tick();
        tick();
        chk("r5_mid_addr", oaddr, 2);
        chk("r5_mid_vld",  ovld,  1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("r5_rst_valid", ovld, 0);
        chk("r5_rst_busy",  busy, 0);
        chk("r5_rst_done",  done, 0);
        chk("r5_rst_err",   err,  0);
        chk("r5_rst_addr",  oaddr, 0);
        chk("r5_rst_data",  odata, 0);
        tick();
        tick();
        chk("r5_no_done", done_cnt, d0);

        // Fresh run after reset; last word writes entry 0
        begin_run();
        tick();
        cap(6'b011000);
        cap(6'b010001);
        cap(6'b001010);
        cap(6'b000011);
        drain("r6", 3'd3, 3'd2, 3'd1, 3'd0, -1, 0);
        chk("r6_err", err, 0);

        // SORT_CYCLES=0: capture opens right after start; a second start is ignored
        ez = '{3'd5, 3'd6, 3'd0, 3'd3};
        start_z = 1'b1;
        tick();
        start_z = 1'b0;
        chk("z_busy", busy_z, 1);
        vld_z = 1'b1;
        pe_z  = 6'b000101;
        tick();
        start_z = 1'b1;
        pe_z    = 6'b001110;
        tick();
        start_z = 1'b0;
        pe_z    = 6'b010000;
        tick();
        pe_z    = 6'b011011;
        tick();
        vld_z = 1'b0;
        pe_z  = '0;
        rdy_z = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("z_vld",  ovld_z,  1);
            chk("z_addr", oaddr_z, i);
            chk("z_data", odata_z, ez[i]);
            tick();
        end
        chk("z_done",  done_z, 1);
        chk("z_idle",  busy_z, 0);
        chk("z_err",   err_z,  0);
        tick();
        chk("z_done_once", done_cnt_z, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
